dft_4: RTL and testbench

Four-point discrete Fourier transform engine: takes four complex samples x0..x3 and produces X0..X3 in natural order. Each sample is a packed fixed-point complex word. This is the radix-4 leaf block used by the 8-point FFT prototype demo. Outputs are registered, with one clock of latency and a valid flag travelling alongside the data.

---
 rtl/dft_4_if.sv | 28 ++
 rtl/dft_4.sv | 92 +++++++++
 tb/tb_dft_4.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dft_4_if.sv
// Bundle of the sample-in / spectrum-out signals of the 4-point DFT engine.
// The master drives samples and observes results; the slave is the engine.
interface dft_4_if #(
  parameter int WORD_SZ = 16
);

  logic               i_valid;
  logic [WORD_SZ-1:0] i_A;
  logic [WORD_SZ-1:0] i_B;
  logic [WORD_SZ-1:0] i_C;
  logic [WORD_SZ-1:0] i_D;
  logic               o_valid;
  logic [WORD_SZ-1:0] o_A;
  logic [WORD_SZ-1:0] o_B;
  logic [WORD_SZ-1:0] o_C;
  logic [WORD_SZ-1:0] o_D;

  modport master (
    output i_valid, i_A, i_B, i_C, i_D,
    input  o_valid, o_A, o_B, o_C, o_D
  );

  modport slave (
    input  i_valid, i_A, i_B, i_C, i_D,
    output o_valid, o_A, o_B, o_C, o_D
  );

endinterface

// File: rtl/dft_4.sv
// Four-point DFT leaf engine: two radix-2 butterfly stages with the -j
// twiddle realised as a component swap and negation. All arithmetic wraps
// modulo 2^HALF per component. One registered cycle of latency; the data
// registers only load on valid input so results hold between bursts.
module dft_4 #(
  parameter int WORD_SZ = 16
) (
  input logic     i_clk,
  input logic     i_rst_n,
  dft_4_if.slave  bus
);

  localparam int HALF = WORD_SZ / 2;

  logic [HALF-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
  logic [HALF-1:0] s0_re, s0_im, d0_re, d0_im;
  logic [HALF-1:0] s1_re, s1_im, d1_re, d1_im;
  logic [HALF-1:0] x0_re, x0_im, x1_re, x1_im;
  logic [HALF-1:0] x2_re, x2_im, x3_re, x3_im;

  logic               valid_d, valid_q;
  logic [WORD_SZ-1:0] a_d, a_q, b_d, b_q, c_d, c_q, d_d, d_q;

  // Unpack the samples and run both butterfly stages; X1/X3 apply -/+ j to d1.
  always_comb begin
    a_re = bus.i_A[WORD_SZ-1:HALF];
    a_im = bus.i_A[HALF-1:0];
    b_re = bus.i_B[WORD_SZ-1:HALF];
    b_im = bus.i_B[HALF-1:0];
    c_re = bus.i_C[WORD_SZ-1:HALF];
    c_im = bus.i_C[HALF-1:0];
    d_re = bus.i_D[WORD_SZ-1:HALF];
    d_im = bus.i_D[HALF-1:0];

    s0_re = a_re + c_re;
    s0_im = a_im + c_im;
    d0_re = a_re - c_re;
    d0_im = a_im - c_im;
    s1_re = b_re + d_re;
    s1_im = b_im + d_im;
    d1_re = b_re - d_re;
    d1_im = b_im - d_im;

    x0_re = s0_re + s1_re;
    x0_im = s0_im + s1_im;
    x2_re = s0_re - s1_re;
    x2_im = s0_im - s1_im;
    x1_re = d0_re + d1_im;
    x1_im = d0_im - d1_re;
    x3_re = d0_re - d1_im;
    x3_im = d0_im + d1_re;
  end

  // Next-state: valid follows the input each cycle, data loads only when valid.
  always_comb begin
    valid_d = bus.i_valid;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    if (bus.i_valid) begin
      a_d = {x0_re, x0_im};
      b_d = {x1_re, x1_im};
      c_d = {x2_re, x2_im};
      d_d = {x3_re, x3_im};
    end
  end

  // Output registers, cleared immediately when reset is asserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_A     = a_q;
  assign bus.o_B     = b_q;
  assign bus.o_C     = c_q;
  assign bus.o_D     = d_q;

endmodule

// File: tb/tb_dft_4.sv
// Self-checking bench for dft_4 (WORD_SZ = 16, HALF = 8): a DFT model built
// from the textbook sum X[k] = sum x[n] * (-j)^(n*k), checked every cycle,
// plus hand-computed literal vectors.
module tb_dft_4;

  localparam int WORD_SZ = 16;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  dft_4_if #(.WORD_SZ(WORD_SZ)) bus ();

  dft_4 #(.WORD_SZ(WORD_SZ)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 i_clk = ~i_clk;

  // Direct DFT: rotate each sample by (-j)^(n*k) and accumulate as integers.
  function automatic logic [3:0][15:0] dftModel(input logic [3:0][15:0] x);
    logic [3:0][15:0] y;
    for (int k = 0; k < 4; k++) begin
      int acc_re;
      int acc_im;
      acc_re = 0;
      acc_im = 0;
      for (int n = 0; n < 4; n++) begin
        int re;
        int im;
        re = int'($signed(x[n][15:8]));
        im = int'($signed(x[n][7:0]));
        case ((n * k) % 4)
          0: begin acc_re += re;  acc_im += im;  end
          1: begin acc_re += im;  acc_im -= re;  end
          2: begin acc_re -= re;  acc_im -= im;  end
          default: begin acc_re -= im; acc_im += re; end
        endcase
      end
      y[k] = {acc_re[7:0], acc_im[7:0]};
    end
    return y;
  endfunction

  // Reference model state, updated like the engine's registered outputs.
  logic             exp_valid = 1'b0;
  logic [3:0][15:0] exp_out   = '0;

  // Model update: clear on reset, load the model spectrum on valid samples.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_valid <= 1'b0;
      exp_out   <= '0;
    end else begin
      exp_valid <= bus.i_valid;
      if (bus.i_valid)
        exp_out <= dftModel({bus.i_D, bus.i_C, bus.i_B, bus.i_A});
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the rising edge.
  always @(negedge i_clk) begin
    compared++;
    if (bus.o_valid !== exp_valid || bus.o_A !== exp_out[0] || bus.o_B !== exp_out[1] ||
        bus.o_C !== exp_out[2] || bus.o_D !== exp_out[3]) begin
      mismatched++;
      $display("[TB] FAIL cycle_model t=%0t: got v=%b %h %h %h %h expected v=%b %h %h %h %h",
               $time, bus.o_valid, bus.o_A, bus.o_B, bus.o_C, bus.o_D,
               exp_valid, exp_out[0], exp_out[1], exp_out[2], exp_out[3]);
    end
  end

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
    bus.i_valid = v;
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_C     = c;
    bus.i_D     = d;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [15:0] ea,
                             input logic [15:0] eb, input logic [15:0] ec, input logic [15:0] ed);
    compared++;
    if (bus.o_valid !== ev || bus.o_A !== ea || bus.o_B !== eb ||
        bus.o_C !== ec || bus.o_D !== ed) begin
      mismatched++;
      $display("[TB] FAIL %s: got v=%b %h %h %h %h expected v=%b %h %h %h %h",
               name, bus.o_valid, bus.o_A, bus.o_B, bus.o_C, bus.o_D, ev, ea, eb, ec, ed);
    end
  endtask

  task automatic checkModel(input string name, input logic [3:0][15:0] got,
                            input logic [3:0][15:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Apply one vector at the falling edge and check the result just after the rising edge.
  task automatic stepCheck(input string name, input logic v,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input logic ev, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [15:0] ec, input logic [15:0] ed);
    @(negedge i_clk);
    applyStimulus(v, a, b, c, d);
    @(posedge i_clk);
    #1;
    checkOutput(name, ev, ea, eb, ec, ed);
  endtask

  initial begin
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Model pinned against hand-computed spectra.
    checkModel("model_ref", dftModel({16'h0502, 16'h0104, 16'h0401, 16'h0203}),
               {16'h02FE, 16'hFA04, 16'h0000, 16'h0C0A});
    checkModel("model_wrap", dftModel({16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80}),
               {16'h0000, 16'h0000, 16'h0000, 16'hFC00});

    // Asynchronous reset before any clock edge.
    #1 i_rst_n = 1'b0;
    #1 checkOutput("reset_state", 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    stepCheck("reference", 1'b1, 16'h0203, 16'h0401, 16'h0104, 16'h0502,
              1'b1, 16'h0C0A, 16'h0000, 16'hFA04, 16'h02FE);
    stepCheck("impulse", 1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
              1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    stepCheck("dc", 1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
              1'b1, 16'h0400, 16'h0000, 16'h0000, 16'h0000);
    stepCheck("wrap", 1'b1, 16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80,
              1'b1, 16'hFC00, 16'h0000, 16'h0000, 16'h0000);

    // Hold: reference result must persist through idle cycles with random inputs.
    stepCheck("hold_ref", 1'b1, 16'h0203, 16'h0401, 16'h0104, 16'h0502,
              1'b1, 16'h0C0A, 16'h0000, 16'hFA04, 16'h02FE);
    for (int i = 0; i < 3; i++)
      stepCheck("hold_idle", 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                1'b0, 16'h0C0A, 16'h0000, 16'hFA04, 16'h02FE);

    // Back-to-back valid vectors, one result per cycle.
    stepCheck("b2b_0", 1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
              1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    stepCheck("b2b_1", 1'b1, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
              1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    stepCheck("b2b_2", 1'b1, 16'h0000, 16'h0100, 16'h0000, 16'h0000,
              1'b1, 16'h0100, 16'h00FF, 16'hFF00, 16'h0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    stepCheck("pre_reset", 1'b1, 16'h0203, 16'h0401, 16'h0104, 16'h0502,
              1'b1, 16'h0C0A, 16'h0000, 16'hFA04, 16'h02FE);

    // Mid-stream reset between edges clears outputs without a clock.
    #2 i_rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    stepCheck("reset_held", 1'b1, 16'h0203, 16'h0401, 16'h0104, 16'h0502,
              1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Release between edges; an idle first edge keeps outputs at zero.
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    @(posedge i_clk);
    #1 checkOutput("release_idle", 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    stepCheck("release_valid", 1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
              1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);

    @(negedge i_clk);
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
